// File: rtl/alu_pkg.sv
// Shared op codes, flag bit positions and capture helpers for the ALU result buffer.
// The optional ALU_RESULT_PARITY_EN build uses even_parity() from here.
package alu_pkg;

    localparam int OP_W  = 3;
    localparam int FLG_W = 4;

    typedef logic [OP_W-1:0]  op_t;
    typedef logic [FLG_W-1:0] flags_t;

    localparam op_t OP_ADD  = 3'b000;
    localparam op_t OP_SUB  = 3'b001;
    localparam op_t OP_DIV  = 3'b010;
    localparam op_t OP_MOD  = 3'b011;
    localparam op_t OP_AND  = 3'b100;
    localparam op_t OP_OR   = 3'b101;
    localparam op_t OP_XOR  = 3'b110;
    localparam op_t OP_XNOR = 3'b111;

    localparam int FLG_ZERO   = 0;
    localparam int FLG_CARRY  = 1;
    localparam int FLG_BORROW = 2;
    localparam int FLG_DZ     = 3;

    localparam logic [16:0] DIVZERO_FILL = 17'h1FFFF;

    function automatic logic is_div_op(input op_t op);
        logic r;
        case (op)
            OP_DIV, OP_MOD: r = 1'b1;
            default:        r = 1'b0;
        endcase
        return r;
    endfunction

    // msb is the ALU carry-out position; it only means carry/borrow for add/sub.
    function automatic flags_t calc_flags(input logic msb, input logic is_zero,
                                          input op_t op, input logic dz);
        flags_t f;
        f             = 4'b0000;
        f[FLG_ZERO]   = is_zero;
        f[FLG_CARRY]  = msb && (op == OP_ADD);
        f[FLG_BORROW] = msb && (op == OP_SUB);
        f[FLG_DZ]     = dz && is_div_op(op);
        return f;
    endfunction

    function automatic logic even_parity(input logic [63:0] d);
        return ^d;
    endfunction

endpackage

// File: rtl/alu_rb_fifo.sv
// Synchronous FIFO whose head entry is held in a register, so the consumer
// sees stable data straight from flops. Callers must never push when full.
module alu_rb_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 24,
    parameter int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [W-1:0]     push_data_i,
    input  logic             pop_i,
    output logic [W-1:0]     head_data_o,
    output logic             head_valid_o,
    output logic [CNT_W-1:0] count_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] remain_s;
    logic [W-1:0]     head_q, head_d;
    logic             valid_q, valid_d;
    logic             pop_s;

    // Next pointers, count and head register contents.
    always_comb begin
        pop_s    = pop_i && valid_q;
        wr_ptr_d = push_i ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
        rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;
        count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_s);
        remain_s = count_q - CNT_W'(pop_s);
        valid_d  = (count_d != {CNT_W{1'b0}});
        head_d   = head_q;
        // An entry landing in an otherwise empty FIFO bypasses storage into the head.
        if (push_i && (remain_s == {CNT_W{1'b0}})) begin
            head_d = push_data_i;
        end else if (remain_s != {CNT_W{1'b0}}) begin
            head_d = mem_q[rd_ptr_d];
        end else begin
            head_d = head_q;
        end
    end

    // Pointer, count and head registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= {PTR_W{1'b0}};
            rd_ptr_q <= {PTR_W{1'b0}};
            count_q  <= {CNT_W{1'b0}};
            head_q   <= {W{1'b0}};
            valid_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
            valid_q  <= valid_d;
        end
    end

    // Entry storage.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= {W{1'b0}};
            end
        end else if (push_i) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign head_data_o  = head_q;
    assign head_valid_o = valid_q;
    assign count_o      = count_q;

endmodule

// File: rtl/alu_result_buffer.sv
// Tracks ops issued to the 1-cycle ALU, captures results with status flags and
// queues them for a valid/ready consumer. Define ALU_RESULT_PARITY_EN for res_parity.
module alu_result_buffer
    import alu_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 17,
    parameter int CNT_W  = $clog2(DEPTH) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              issue_valid,
    output logic              issue_ready,
    input  logic [2:0]        issue_select,
    input  logic              issue_divzero,
    input  logic [DATA_W-1:0] alu_out,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic [2:0]        res_op,
    output logic [3:0]        res_flags,
    output logic [CNT_W-1:0]  occupancy
`ifdef ALU_RESULT_PARITY_EN
    ,
    output logic              res_parity
`endif
);

`ifdef ALU_RESULT_PARITY_EN
    localparam int PAR_W = 1;
`else
    localparam int PAR_W = 0;
`endif
    localparam int ENTRY_W = DATA_W + OP_W + FLG_W + PAR_W;
    localparam int SUM_W   = CNT_W + 1;

    logic               pend_valid_q, pend_valid_d;
    op_t                pend_op_q, pend_op_d;
    logic               pend_dz_q, pend_dz_d;
    logic               accept_s;
    logic [SUM_W-1:0]   credit_sum_s;
    logic               cap_zero_s;
    flags_t             cap_flags_s;
    logic [DATA_W-1:0]  cap_data_s;
    logic [ENTRY_W-1:0] push_entry_s;
    logic [ENTRY_W-1:0] head_entry_s;
    logic               pop_s;

    // Credits count both queued entries and the op still in flight in the ALU.
    always_comb begin
        credit_sum_s = {1'b0, occupancy} + SUM_W'(pend_valid_q);
        issue_ready  = (credit_sum_s < SUM_W'(DEPTH));
        accept_s     = issue_valid && issue_ready;
    end

    // Pending-stage next state.
    always_comb begin
        pend_valid_d = accept_s;
        pend_op_d    = pend_op_q;
        pend_dz_d    = pend_dz_q;
        if (accept_s) begin
            pend_op_d = issue_select;
            pend_dz_d = issue_divzero;
        end else begin
            pend_op_d = pend_op_q;
            pend_dz_d = pend_dz_q;
        end
    end

    // Pending-stage registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pend_valid_q <= 1'b0;
            pend_op_q    <= OP_ADD;
            pend_dz_q    <= 1'b0;
        end else begin
            pend_valid_q <= pend_valid_d;
            pend_op_q    <= pend_op_d;
            pend_dz_q    <= pend_dz_d;
        end
    end

    // Flag derivation and entry assembly for the result arriving this cycle.
    always_comb begin
        cap_zero_s  = (alu_out == {DATA_W{1'b0}});
        cap_flags_s = calc_flags(alu_out[DATA_W-1], cap_zero_s, pend_op_q, pend_dz_q);
        if (cap_flags_s[FLG_DZ]) begin
            cap_data_s = DATA_W'(DIVZERO_FILL);
        end else begin
            cap_data_s = alu_out;
        end
`ifdef ALU_RESULT_PARITY_EN
        push_entry_s = {even_parity(64'(cap_data_s)), cap_flags_s, pend_op_q, cap_data_s};
`else
        push_entry_s = {cap_flags_s, pend_op_q, cap_data_s};
`endif
    end

    assign pop_s = res_valid && res_ready;

    alu_rb_fifo #(
        .DEPTH (DEPTH),
        .W     (ENTRY_W),
        .CNT_W (CNT_W)
    ) u_fifo (
        .clk_i        (clock),
        .rst_ni       (reset),
        .push_i       (pend_valid_q),
        .push_data_i  (push_entry_s),
        .pop_i        (pop_s),
        .head_data_o  (head_entry_s),
        .head_valid_o (res_valid),
        .count_o      (occupancy)
    );

    assign res_data  = head_entry_s[DATA_W-1:0];
    assign res_op    = head_entry_s[DATA_W +: OP_W];
    assign res_flags = head_entry_s[DATA_W+OP_W +: FLG_W];
`ifdef ALU_RESULT_PARITY_EN
    assign res_parity = head_entry_s[ENTRY_W-1];
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer with a one-cycle registered ALU stand-in.
module tb_alu_result_buffer;
    import alu_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        issue_valid = 1'b0;
    logic        issue_ready;
    logic [2:0]  issue_select = 3'b000;
    logic        issue_divzero = 1'b0;
    logic [16:0] alu_out;
    logic [16:0] alu_next = 17'h00000;
    logic        res_valid;
    logic        res_ready = 1'b0;
    logic [16:0] res_data;
    logic [2:0]  res_op;
    logic [3:0]  res_flags;
    logic [2:0]  occupancy;
`ifdef ALU_RESULT_PARITY_EN
    logic        res_parity;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    alu_result_buffer dut (
        .clock         (clock),
        .reset         (reset),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_select  (issue_select),
        .issue_divzero (issue_divzero),
        .alu_out       (alu_out),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_data      (res_data),
        .res_op        (res_op),
        .res_flags     (res_flags),
        .occupancy     (occupancy)
`ifdef ALU_RESULT_PARITY_EN
        ,
        .res_parity    (res_parity)
`endif
    );

    always #5 clock = ~clock;

    always @(posedge clock or negedge reset) begin
        if (!reset) alu_out <= 17'h00000;
        else        alu_out <= alu_next;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_assert++;
        assert (obs === exp_v) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic do_single(input logic [2:0] op, input logic dz, input logic [16:0] res,
                             input logic [16:0] exp_d, input logic [3:0] exp_f);
        chk("ready_before_issue", 32'(issue_ready), 32'd1);
        issue_valid = 1'b1; issue_select = op; issue_divzero = dz; alu_next = res;
        step();
        issue_valid = 1'b0; issue_divzero = 1'b0; alu_next = 17'h00000;
        chk("not_valid_at_t1", 32'(res_valid), 32'd0);
        step();
        chk("valid_at_t2", 32'(res_valid), 32'd1);
        chk("single_data", 32'(res_data), 32'(exp_d));
        chk("single_op", 32'(res_op), 32'(op));
        chk("single_flags", 32'(res_flags), 32'(exp_f));
        chk("single_occ", 32'(occupancy), 32'd1);
`ifdef ALU_RESULT_PARITY_EN
        chk("single_parity", 32'(res_parity), 32'(^exp_d));
`endif
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("pop_clears_valid", 32'(res_valid), 32'd0);
        chk("pop_clears_occ", 32'(occupancy), 32'd0);
    endtask

    initial begin
        // Reset values while held in reset.
        #3;
        chk("rst_valid", 32'(res_valid), 32'd0);
        chk("rst_data", 32'(res_data), 32'd0);
        chk("rst_op", 32'(res_op), 32'd0);
        chk("rst_flags", 32'(res_flags), 32'd0);
        chk("rst_occ", 32'(occupancy), 32'd0);
        @(posedge clock); @(posedge clock); #1;
        reset = 1'b1;
        chk("rel_ready", 32'(issue_ready), 32'd1);
        step();

        // Single ops through each flag path.
        do_single(OP_ADD,  1'b0, 17'h10000, 17'h10000, 4'b0010);
        do_single(OP_DIV,  1'b1, 17'h00003, 17'h1FFFF, 4'b1000);
        do_single(OP_DIV,  1'b0, 17'h00005, 17'h00005, 4'b0000);
        do_single(OP_MOD,  1'b1, 17'h00000, 17'h1FFFF, 4'b1001);
        do_single(OP_SUB,  1'b0, 17'h1FFFE, 17'h1FFFE, 4'b0100);
        do_single(OP_AND,  1'b0, 17'h00000, 17'h00000, 4'b0001);
        do_single(OP_XOR,  1'b1, 17'h10000, 17'h10000, 4'b0000);
        do_single(OP_ADD,  1'b0, 17'h00007, 17'h00007, 4'b0000);

        // Back-pressure: six attempts, four accepted.
        res_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            issue_valid = 1'b1; issue_select = 3'(4 + (i % 4)); alu_next = 17'(32'h100 + i);
            chk("bp_ready", 32'(issue_ready), (i < 4) ? 32'd1 : 32'd0);
            step();
        end
        issue_valid = 1'b0; alu_next = 17'h00000;
        chk("full_occ", 32'(occupancy), 32'd4);
        chk("full_ready", 32'(issue_ready), 32'd0);
        chk("full_valid", 32'(res_valid), 32'd1);
        chk("full_head_data", 32'(res_data), 32'h100);
        chk("full_head_op", 32'(res_op), 32'd4);
        res_ready = 1'b1;
        step();
        chk("ready_after_pop", 32'(issue_ready), 32'd1);
        chk("occ_after_pop", 32'(occupancy), 32'd3);
        chk("drain_data", 32'(res_data), 32'h101);
        chk("drain_op", 32'(res_op), 32'd5);
        for (int k = 2; k < 4; k++) begin
            step();
            chk("drain_data", 32'(res_data), 32'(32'h100 + k));
            chk("drain_op", 32'(res_op), 32'(4 + k));
        end
        step();
        res_ready = 1'b0;
        chk("drained_valid", 32'(res_valid), 32'd0);
        chk("drained_occ", 32'(occupancy), 32'd0);

        // Streaming: 20 ops, one result per cycle, pointers wrap.
        res_ready = 1'b1;
        for (int c = 0; c < 22; c++) begin
            if (c < 20) begin
                issue_valid = 1'b1; issue_select = 3'(c % 8); issue_divzero = 1'b0;
                alu_next = 17'(32'h200 + c);
                chk("stream_ready", 32'(issue_ready), 32'd1);
            end else begin
                issue_valid = 1'b0; alu_next = 17'h00000;
            end
            if (c >= 2) begin
                chk("stream_valid", 32'(res_valid), 32'd1);
                chk("stream_data", 32'(res_data), 32'(32'h200 + c - 2));
                chk("stream_op", 32'(res_op), 32'((c - 2) % 8));
                chk("stream_flags", 32'(res_flags), 32'd0);
                chk("stream_occ", 32'(occupancy), 32'd1);
            end
            step();
        end
        res_ready = 1'b0;
        chk("stream_end_valid", 32'(res_valid), 32'd0);
        chk("stream_end_occ", 32'(occupancy), 32'd0);

        // Asynchronous reset with three queued and one pending.
        for (int i = 0; i < 4; i++) begin
            issue_valid = 1'b1; issue_select = OP_ADD; alu_next = 17'(32'h300 + i);
            step();
        end
        issue_valid = 1'b0; alu_next = 17'h00000;
        chk("pre_rst_occ", 32'(occupancy), 32'd3);
        chk("pre_rst_ready", 32'(issue_ready), 32'd0);
        #1 reset = 1'b0;
        #1;
        chk("async_valid", 32'(res_valid), 32'd0);
        chk("async_occ", 32'(occupancy), 32'd0);
        chk("async_data", 32'(res_data), 32'd0);
        chk("async_op", 32'(res_op), 32'd0);
        chk("async_flags", 32'(res_flags), 32'd0);
        chk("async_ready", 32'(issue_ready), 32'd1);
        step(); step();
        reset = 1'b1;
        step(); step();
        chk("post_rst_valid", 32'(res_valid), 32'd0);
        chk("post_rst_occ", 32'(occupancy), 32'd0);
        do_single(OP_ADD, 1'b0, 17'h00000, 17'h00000, 4'b0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
